// File: rtl/sobel_stream_detector.sv
// Streaming Sobel edge detector: one raster pixel per clock in, a 3x3
// window built from two line buffers, L1/Linf gradient magnitude compared
// against a frame-latched threshold. Four-stage pipeline with the syncs
// delay-matched.
//
// Handshake: there is no backpressure. A pixel is accepted on every clock
// edge where de=1; each output slot is valid exactly four cycles after its
// input slot, and de_out marks which output slots carry pixels.
module sobel_stream_detector #(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int MAG_W     = PIX_W + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [MAG_W-1:0] threshold,
    input  logic             mode,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out,
    output logic             edge_out,
    output logic [PIX_W-1:0] mag_out
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int CW = $clog2(MAX_WIDTH + 1) + 1;
    localparam int LW = 12;
    localparam int GW = PIX_W + 4;

    localparam logic [CW-1:0]    MAX_COL = CW'(MAX_WIDTH);
    localparam logic [CW-1:0]    COL_2   = CW'(2);
    localparam logic [LW-1:0]    LINE_2  = LW'(2);
    localparam logic [MAG_W-1:0] PIX_MAX = MAG_W'((1 << PIX_W) - 1);

    // Frame configuration shadows
    logic [MAG_W-1:0] thr_q;
    logic             mode_q;

    // Raster position tracking
    logic [CW-1:0] col_cnt;
    logic [LW-1:0] line_cnt;
    logic          vsync_q;
    logic          de_q;
    logic          vsync_rise;
    logic          de_fall;
    logic          in_range;

    // Line buffers
    logic [PIX_W-1:0] lb0 [MAX_WIDTH];
    logic [PIX_W-1:0] lb1 [MAX_WIDTH];
    logic [AW-1:0]    lb_addr;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // Column history: c1 = one column back, c2 = two columns back
    logic [PIX_W-1:0] c1_t, c1_m, c1_b;
    logic [PIX_W-1:0] c2_t, c2_m, c2_b;

    // Pipeline stages
    logic [PIX_W-1:0]    win [9];
    logic                s1_valid;
    logic signed [GW-1:0] gx_c, gy_c;
    logic signed [GW-1:0] gx_q, gy_q;
    logic                s2_valid;
    logic [MAG_W-1:0]    ax_c, ay_c, mag_c;
    logic [MAG_W-1:0]    mag_q;
    logic                s3_valid;
    logic [3:0]          hs_d, vs_d, de_d;

    assign vsync_rise = vsync & ~vsync_q;
    assign de_fall    = ~de & de_q;
    assign in_range   = (col_cnt < MAX_COL);
    assign lb_addr    = col_cnt[AW-1:0];
    assign lb0_rd     = lb0[lb_addr];
    assign lb1_rd     = lb1[lb_addr];

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    // Threshold and norm select follow the ports during reset, then only at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q  <= threshold;
            mode_q <= mode;
        end else if (vsync_rise) begin
            thr_q  <= threshold;
            mode_q <= mode;
        end
    end

    // Column/line counters; saturating, cleared at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt  <= '0;
            line_cnt <= '0;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            vsync_q <= vsync;
            de_q    <= de;
            if (vsync_rise) begin
                col_cnt  <= '0;
                line_cnt <= '0;
            end else begin
                if (de) begin
                    if (col_cnt != '1) col_cnt <= col_cnt + CW'(1);
                end else begin
                    col_cnt <= '0;
                end
                if (de_fall && line_cnt != '1) line_cnt <= line_cnt + LW'(1);
            end
        end
    end

    // Read-before-write line buffers: lb0 holds the previous line, lb1 the one before
    always_ff @(posedge clk) begin
        if (de && in_range) begin
            lb0[lb_addr] <= pixel_in;
            lb1[lb_addr] <= lb0_rd;
        end
    end

    // Shift the three window rows one column on every accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_t <= '0; c1_m <= '0; c1_b <= '0;
            c2_t <= '0; c2_m <= '0; c2_b <= '0;
        end else if (de) begin
            c2_t <= c1_t;   c2_m <= c1_m;   c2_b <= c1_b;
            c1_t <= lb1_rd; c1_m <= lb0_rd; c1_b <= pixel_in;
        end
    end

    // Sobel kernels on the registered window (p1..p9 = win[0..8])
    always_comb begin
        gx_c = (ext(win[2]) + (ext(win[5]) <<< 1) + ext(win[8]))
             - (ext(win[0]) + (ext(win[3]) <<< 1) + ext(win[6]));
        gy_c = (ext(win[6]) + (ext(win[7]) <<< 1) + ext(win[8]))
             - (ext(win[0]) + (ext(win[1]) <<< 1) + ext(win[2]));
    end

    // Absolute values and the selected norm
    always_comb begin
        ax_c  = gx_q[GW-1] ? MAG_W'(-gx_q) : MAG_W'(gx_q);
        ay_c  = gy_q[GW-1] ? MAG_W'(-gy_q) : MAG_W'(gy_q);
        mag_c = mode_q ? ((ax_c > ay_c) ? ax_c : ay_c) : (ax_c + ay_c);
    end

    // Four-stage datapath: window, gradients, magnitude, compare/saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            s1_valid <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            s2_valid <= 1'b0;
            mag_q    <= '0;
            s3_valid <= 1'b0;
            edge_out <= 1'b0;
            mag_out  <= '0;
        end else begin
            win[0] <= c2_t; win[1] <= c1_t; win[2] <= lb1_rd;
            win[3] <= c2_m; win[4] <= c1_m; win[5] <= lb0_rd;
            win[6] <= c2_b; win[7] <= c1_b; win[8] <= pixel_in;
            s1_valid <= de && (line_cnt >= LINE_2) && (col_cnt >= COL_2) && in_range;
            gx_q     <= gx_c;
            gy_q     <= gy_c;
            s2_valid <= s1_valid;
            mag_q    <= mag_c;
            s3_valid <= s2_valid;
            edge_out <= s3_valid && (mag_q > thr_q);
            if (!s3_valid)          mag_out <= '0;
            else if (mag_q > PIX_MAX) mag_out <= '1;
            else                    mag_out <= mag_q[PIX_W-1:0];
        end
    end

    // Sync delay lines matching the datapath depth
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d <= '0;
            vs_d <= '0;
            de_d <= '0;
        end else begin
            hs_d <= {hs_d[2:0], hsync};
            vs_d <= {vs_d[2:0], vsync};
            de_d <= {de_d[2:0], de};
        end
    end

    assign hsync_out = hs_d[3];
    assign vsync_out = vs_d[3];
    assign de_out    = de_d[3];

endmodule

// File: tb/tb_sobel_stream_detector.sv
// Directed bench for sobel_stream_detector with an 8-pixel line buffer.
// Each driven cycle pushes its hand-computed output slot into exp_q; the
// slot is checked against the outputs four cycles later.
module tb_sobel_stream_detector;

    localparam int PIX_W     = 8;
    localparam int MAX_WIDTH = 8;
    localparam int MAG_W     = 11;

    // Line images: byte c (bits [c*8 +: 8]) is column c
    localparam logic [95:0] L_ZERO   = 96'h00000000_00000000_00000000;
    localparam logic [95:0] L_VERT   = 96'h00000000_ffffffff_ff000000;
    localparam logic [95:0] L_201    = 96'h00000000_c9c9c9c9_c9c9c9c9;
    localparam logic [95:0] L_150    = 96'h00000000_96969696_96969696;
    localparam logic [95:0] L_100    = 96'h00000000_64646464_64646464;
    localparam logic [95:0] L_FF     = 96'h00000000_ffffffff_ffffffff;
    localparam logic [95:0] L_CORNER = 96'h00000000_00000000_000000ff;
    localparam logic [95:0] L_SMALL  = 96'h00000000_14141414_14000000;
    localparam logic [95:0] L_LONG   = 96'h64646464_ffffffff_ff000000;

    // Hand-computed expected edge bits and magnitudes per column
    localparam logic [11:0] E_NONE   = 12'h000;
    localparam logic [11:0] E_VERT   = 12'h018;
    localparam logic [11:0] E_ROW    = 12'h0fc;
    localparam logic [11:0] E_ROW3   = 12'h0f8;
    localparam logic [95:0] M_NONE   = 96'h00000000_00000000_00000000;
    localparam logic [95:0] M_VERT   = 96'h00000000_000000ff_ff000000;
    localparam logic [95:0] M_ROW    = 96'h00000000_ffffffff_ffff0000;
    localparam logic [95:0] M_SMALL  = 96'h00000000_00000050_50000000;

    logic             clk;
    logic             rst;
    logic [PIX_W-1:0] pixel_in;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [MAG_W-1:0] threshold;
    logic             mode;
    logic             hsync_out;
    logic             vsync_out;
    logic             de_out;
    logic             edge_out;
    logic [PIX_W-1:0] mag_out;

    int          total;
    int          bad;
    string       cur_tag;
    logic [11:0] exp_q[$];

    sobel_stream_detector #(
        .PIX_W    (PIX_W),
        .MAX_WIDTH(MAX_WIDTH),
        .MAG_W    (MAG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pixel_in (pixel_in),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .threshold(threshold),
        .mode     (mode),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .de_out   (de_out),
        .edge_out (edge_out),
        .mag_out  (mag_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // One cycle: drive, queue its expected output slot, check the slot from four cycles back
    task automatic step(input logic [7:0] pix, input logic hs, input logic vs,
                        input logic d, input logic e, input logic [7:0] m);
        logic [11:0] x;
        pixel_in = pix;
        hsync    = hs;
        vsync    = vs;
        de       = d;
        exp_q.push_back({hs, vs, d, e, m});
        @(negedge clk);
        if (exp_q.size() > 4) begin
            x = exp_q.pop_front();
            check(cur_tag, {20'b0, hsync_out, vsync_out, de_out, edge_out, mag_out}, {20'b0, x});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input logic [95:0] pix, input int w,
                             input logic [11:0] edg, input logic [95:0] mag);
        for (int c = 0; c < w; c++)
            step(pix[c*8 +: 8], 1'b0, 1'b0, 1'b1, edg[c], mag[c*8 +: 8]);
        step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        pixel_in  = '0;
        hsync     = 1'b0;
        vsync     = 1'b0;
        de        = 1'b0;
        threshold = '0;
        mode      = 1'b0;
        @(posedge clk);
        #1;

        // Reset with random inputs: every output held at zero
        for (int i = 0; i < 5; i++) begin
            pixel_in  = 8'($urandom_range(0, 255));
            hsync     = 1'($urandom_range(0, 1));
            vsync     = 1'($urandom_range(0, 1));
            de        = 1'($urandom_range(0, 1));
            threshold = 11'($urandom_range(0, 2047));
            mode      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("reset", {20'b0, hsync_out, vsync_out, de_out, edge_out, mag_out}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(12'h000);
        cur_tag = "idle";
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Flat frame: nothing but delayed syncs
        cur_tag = "flat";
        threshold = 11'd400;
        mode      = 1'b0;
        vsync_pulse();
        for (int l = 0; l < 4; l++) send_line(L_ZERO, 8, E_NONE, M_NONE);

        // Vertical edge; threshold raised mid-frame must not take effect yet
        cur_tag = "vert_edge";
        vsync_pulse();
        send_line(L_VERT, 8, E_NONE, M_NONE);
        send_line(L_VERT, 8, E_NONE, M_NONE);
        threshold = 11'd2000;
        send_line(L_VERT, 8, E_VERT, M_VERT);
        send_line(L_VERT, 8, E_VERT, M_VERT);

        // Next frame latches 2000: magnitude still saturates, no edges
        cur_tag = "latched_2000";
        vsync_pulse();
        send_line(L_VERT, 8, E_NONE, M_NONE);
        send_line(L_VERT, 8, E_NONE, M_NONE);
        send_line(L_VERT, 8, E_NONE, M_VERT);
        send_line(L_VERT, 8, E_NONE, M_VERT);

        // Horizontal gradient |Gy| = 404 against threshold 400
        cur_tag = "thr_400";
        threshold = 11'd400;
        vsync_pulse();
        send_line(L_201, 8, E_NONE, M_NONE);
        send_line(L_150, 8, E_NONE, M_NONE);
        send_line(L_100, 8, E_ROW, M_ROW);

        // Same image, threshold 404: strict compare gives no edge
        cur_tag = "thr_404";
        threshold = 11'd404;
        vsync_pulse();
        send_line(L_201, 8, E_NONE, M_NONE);
        send_line(L_150, 8, E_NONE, M_NONE);
        send_line(L_100, 8, E_NONE, M_ROW);

        // Corner window: L1 = 1530 at col 2, |Gy| = 1020 further right
        cur_tag = "mode_l1";
        threshold = 11'd1000;
        mode      = 1'b0;
        vsync_pulse();
        send_line(L_FF, 8, E_NONE, M_NONE);
        send_line(L_CORNER, 8, E_NONE, M_NONE);
        send_line(L_CORNER, 8, E_ROW, M_ROW);

        // Linf: col 2 drops to 765, cols 3..7 stay at 1020
        cur_tag = "mode_linf";
        mode = 1'b1;
        vsync_pulse();
        send_line(L_FF, 8, E_NONE, M_NONE);
        send_line(L_CORNER, 8, E_NONE, M_NONE);
        send_line(L_CORNER, 8, E_ROW3, M_ROW);

        // Small step of 20: unsaturated magnitude 80 against threshold 50
        cur_tag = "small_grad";
        threshold = 11'd50;
        mode      = 1'b0;
        vsync_pulse();
        send_line(L_SMALL, 8, E_NONE, M_NONE);
        send_line(L_SMALL, 8, E_NONE, M_NONE);
        send_line(L_SMALL, 8, E_VERT, M_SMALL);

        // Overlong 12-pixel lines: cols 8..11 are border, cols 0..7 unaffected
        cur_tag = "overlong";
        threshold = 11'd400;
        vsync_pulse();
        send_line(L_LONG, 12, E_NONE, M_NONE);
        send_line(L_LONG, 12, E_NONE, M_NONE);
        send_line(L_LONG, 12, E_VERT, M_VERT);
        send_line(L_LONG, 12, E_VERT, M_VERT);
        send_line(L_VERT, 8, E_VERT, M_VERT);

        // Drain the last queued slots
        cur_tag = "drain";
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_stream_detector.md
Name: sobel_stream_detector

Overview:
- Streaming Sobel edge detector. Accepts one raster pixel per clock with hsync/vsync/de.
- Builds the 3x3 window internally from two line buffers, so upstream no longer supplies nine pixels.
- Computes the gradient magnitude in a selectable norm and compares it against a frame-latched threshold.
- Outputs a binary edge flag and a saturated magnitude, both delay-matched with the syncs. Sits between the video input stage and the overlay/output stage.

Parameters:
- PIX_W, 8: pixel bit width.
- MAX_WIDTH, 1024: line-buffer depth, i.e. the maximum active pixels per line.
- MAG_W, PIX_W+3: internal magnitude width. Worst-case |Gx|+|Gy| = 8*(2^PIX_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pixel_in  in  PIX_W  grayscale pixel, valid when de=1.
- hsync  in  1  horizontal sync, pass-through.
- vsync  in  1  vertical sync, active-high; its rising edge marks frame start.
- de  in  1  data enable.
- threshold  in  MAG_W  edge threshold; latched, not live.
- mode  in  1  norm select: 0 = |Gx|+|Gy|, 1 = max(|Gx|,|Gy|); latched.
- hsync_out, vsync_out, de_out  out  1 each  syncs delayed by LAT.
- edge_out  out  1  1 when the window magnitude is strictly greater than the latched threshold.
- mag_out  out  PIX_W  magnitude saturated to 2^PIX_W-1.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset:
  - All outputs = 0; col_cnt = 0; line_cnt = 0; all pipeline and sync delay registers cleared.
  - Shadow registers load from threshold/mode while rst=1.
  - Line-buffer RAM is not cleared. Stale data is masked by the border rule.
- Config latch: thr_q and mode_q reload from the ports on every vsync rising edge (vsync=1 while the previous vsync was 0). Changes at any other time have no effect until the next frame.
- Counters:
  - col_cnt increments on each de=1 cycle and clears on the cycle after de falls.
  - line_cnt increments when de falls (1 -> 0) and clears on the vsync rising edge.
  - Both counters saturate; neither wraps.
- Line buffers:
  - Two RAMs, read-before-write at address col_cnt, written only when de=1 and col_cnt < MAX_WIDTH.
  - lb0 receives pixel_in; lb1 receives lb0's old read data.
  - Pixels at col_cnt >= MAX_WIDTH are not stored and are treated as border.
- Window:
  - Three 3-deep column shift registers, shifting on de=1.
  - p1..p9 are row-major with p1 = top-left (2 lines up, 2 columns back); p9 = current pixel_in.
  - Output is spatially centred on (line_cnt-1, col_cnt-1).
- Arithmetic:
  - Gx = (p3+2p6+p9)-(p1+2p4+p7) and Gy = (p7+2p8+p9)-(p1+2p2+p3), signed, PIX_W+4 bits.
  - Magnitude is L1 or Linf per mode_q, in MAG_W bits unsigned with no overflow.
- Pipeline (LAT = 4): S1 window register; S2 Gx/Gy; S3 abs and norm; S4 compare, saturate, output register.
- Timing: inputs sampled at edge k appear on all outputs at edge k+4. hsync/vsync/de pass through 4-stage delays, so outputs stay aligned.
- Border: if line_cnt < 2, col_cnt < 2, col_cnt >= MAX_WIDTH or de = 0 at sampling, then edge_out = 0 and mag_out = 0 for that slot. de_out still mirrors the delayed de.
- Back-to-back frames: a vsync rising edge mid-line clears the counters immediately. The pipeline continues to drain in flight with no flush.
- Reset mid-frame: the pipeline is flushed. The first two lines after the next vsync edge are border.

Test Plan:
- Reset: rst=1 for 5 cycles with random inputs -> every output 0. After release, flat frame 8x4 of 0s, threshold=400, mode=0 -> edge_out=0, mag_out=0 throughout; de_out equals de delayed exactly 4 cycles.
- Vertical edge, line width 8 with each line = 0,0,0,255,255,255,255,255, threshold=400, mode=0:
  - line_cnt >= 2, col 3 and col 4 -> Gx = 1020, mag 1020, edge_out=1, mag_out=255.
  - col 5 onward -> edge_out=0.
  - lines 0-1 and cols 0-1 -> edge_out=0.
- Threshold boundary, lines of constant 201, 150, 100: at line 2, col >= 2, |Gy| = 404.
  - threshold=400 -> edge_out=1, mag_out=255.
  - Next frame with threshold=404 -> edge_out=0 (strict compare).
- Mode, window rows 255,255,255 / 255,0,0 / 255,0,0 (Gx = Gy = -765), threshold=1000:
  - mode=0 (mag 1530) -> edge_out=1.
  - mode=1 (mag 765) -> edge_out=0.
- Config latch: change threshold from 400 to 2000 mid-frame on the vertical-edge image -> edges persist for the rest of the frame and disappear only after the next vsync rising edge.
- Overlong line, MAX_WIDTH=8 with a 12-pixel line -> cols 8..11 give edge_out=0 and mag_out=0. The following lines stay correctly aligned; no buffer corruption at cols 0..7.
